md_sequencer: RTL

MD_SEQUENCER -- requirements
Module: md_sequencer

---
 rtl/md_sequencer_if.sv | 17 +
 rtl/md_sequencer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/md_sequencer_if.sv
// HI/LO sequencer request/result bundle between the Ex stage and md_sequencer.
interface md_sequencer_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        commit_en;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        done;

   modport master (output start, op, op_a, op_b, commit_en,
                   input  busy, hi, lo, done);
   modport slave  (input  start, op, op_a, op_b, commit_en,
                   output busy, hi, lo, done);
endinterface

// File: rtl/md_sequencer.sv
// Multi-cycle mult/div sequencer owning the architectural HI/LO registers.
// Results are computed from operands latched at acceptance and written
// on the final busy edge; mthi/mtlo write HI/LO directly from IDLE.
module md_sequencer #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic          clk,
   input logic          reset,
   md_sequencer_if.slave bus
);
   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [31:0]     a_q, a_d, b_q, b_d;
   logic            sgn_q, sgn_d;
   logic [31:0]     hi_q, hi_d, lo_q, lo_d;
   logic            done_q, done_d;

   logic [63:0]     prod;
   logic [31:0]     quo, rem;

   // Datapath: 64-bit product and sign-magnitude division of latched operands.
   always_comb begin
      logic [63:0] ae, be;
      logic [31:0] ua, ub, ub_safe, qm, rm;
      ae      = {{32{sgn_q & a_q[31]}}, a_q};
      be      = {{32{sgn_q & b_q[31]}}, b_q};
      prod    = ae * be;
      ua      = (sgn_q && a_q[31]) ? (32'd0 - a_q) : a_q;
      ub      = (sgn_q && b_q[31]) ? (32'd0 - b_q) : b_q;
      // Divide-by-zero result is discarded; keep the divider input benign.
      ub_safe = (ub == 32'd0) ? 32'd1 : ub;
      qm      = ua / ub_safe;
      rm      = ua % ub_safe;
      // Quotient truncates toward zero; remainder follows the dividend's sign.
      // 0x80000000 / -1 wraps back to 0x80000000 through the negation.
      quo     = (sgn_q && (a_q[31] ^ b_q[31])) ? (32'd0 - qm) : qm;
      rem     = (sgn_q && a_q[31]) ? (32'd0 - rm) : rm;
   end

   // Next-state: acceptance, countdown and HI/LO write-back.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      sgn_d   = sgn_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start && bus.commit_en) begin
               unique case (bus.op)
                  3'd0, 3'd1: begin
                     a_d     = bus.op_a;
                     b_d     = bus.op_b;
                     sgn_d   = ~bus.op[0];
                     cnt_d   = CW'(MULT_CYCLES);
                     state_d = MUL;
                  end
                  3'd2, 3'd3: begin
                     a_d     = bus.op_a;
                     b_d     = bus.op_b;
                     sgn_d   = ~bus.op[0];
                     cnt_d   = CW'(DIV_CYCLES);
                     state_d = DIV;
                  end
                  3'd4:    hi_d = bus.op_a;
                  3'd5:    lo_d = bus.op_a;
                  default: ;
               endcase
            end
         end
         MUL: begin
            if (cnt_q == CW'(1)) begin
               {hi_d, lo_d} = prod;
               done_d       = 1'b1;
               cnt_d        = '0;
               state_d      = IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DIV: begin
            if (cnt_q == CW'(1)) begin
               if (b_q != 32'd0) begin
                  hi_d = rem;
                  lo_d = quo;
               end
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset aborts any in-flight operation.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sgn_q   <= sgn_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = (state_q != IDLE);
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
   assign bus.done = done_q;
endmodule
